// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the ALU issue controller and its environment: instruction
// handshake, register-file read/write ports, ALU drive/capture and status.
interface alu_issue_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] rf_ra_addr;
  logic [AW-1:0] rf_rb_addr;
  logic [DW-1:0] rf_ra_data;
  logic [DW-1:0] rf_rb_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_carry;
  logic          alu_zf;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          carry_flag;
  logic          zero_flag;
  logic          done;
  logic          skipped;
  logic          illegal;

  // Controller side
  modport master (
    input  instr_valid, instr, rf_ra_data, rf_rb_data, alu_out, alu_carry, alu_zf,
    output instr_ready, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_op,
           rf_we, rf_wa, rf_wd, carry_flag, zero_flag, done, skipped, illegal
  );

  // Environment side: instruction source, register file and ALU
  modport slave (
    output instr_valid, instr, rf_ra_data, rf_rb_data, alu_out, alu_carry, alu_zf,
    input  instr_ready, rf_ra_addr, rf_rb_addr, alu_a, alu_b, alu_op,
           rf_we, rf_wa, rf_wd, carry_flag, zero_flag, done, skipped, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multicycle issue controller for ADD/ADI/NDU: reads operands, drives the
// ALU, writes back and keeps the architectural C and Z flags.
// Fixed latency: accept -> OPS -> EXEC -> WB (done three cycles after accept).
module alu_issue_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, OPS, EXEC, WB} state_t;

  localparam logic [3:0] OPC_ADD = 4'b0000;
  localparam logic [3:0] OPC_ADI = 4'b0001;
  localparam logic [3:0] OPC_NDU = 4'b0010;

  state_t        state_q, state_d;
  logic [3:0]    opc_q;
  logic [5:0]    imm_q;         // low instruction bits; CZ lives in [1:0]
  logic [AW-1:0] ra_q, rb_q, wa_q;
  logic [DW-1:0] a_q, b_q, res_q;
  logic          carry_q, zf_q;
  logic          exec_q, skip_q, illegal_q;
  logic          carry_flag_q, zero_flag_q;

  logic          accept;
  logic          is_adi, is_ndu, legal, cond_ok;
  logic [1:0]    cz;
  logic [DW-1:0] imm_sext;

  assign accept   = (state_q == IDLE) && bus.instr_valid;
  assign cz       = imm_q[1:0];
  assign is_adi   = (opc_q == OPC_ADI);
  assign is_ndu   = (opc_q == OPC_NDU);
  assign imm_sext = {{(DW-6){imm_q[5]}}, imm_q};

  // Legality: ADI ignores CZ; ADD/NDU reject CZ=11; any other opcode is illegal
  assign legal   = is_adi || (((opc_q == OPC_ADD) || is_ndu) && (cz != 2'b11));
  assign cond_ok = is_adi || (cz == 2'b00) ||
                   ((cz == 2'b10) && carry_flag_q) ||
                   ((cz == 2'b01) && zero_flag_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobes
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    bus.alu_op      = 2'b00;
    bus.done        = 1'b0;
    bus.rf_we       = 1'b0;
    bus.skipped     = 1'b0;
    bus.illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = OPS;
      end
      OPS:  state_d = EXEC;
      EXEC: begin
        bus.alu_op = is_ndu ? 2'b10 : 2'b00;
        state_d    = WB;
      end
      WB: begin
        bus.done    = 1'b1;
        bus.rf_we   = exec_q;
        bus.skipped = skip_q;
        bus.illegal = illegal_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction latch, operand fetch, decode result and ALU capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q     <= '0;
      imm_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      zf_q      <= 1'b0;
      exec_q    <= 1'b0;
      skip_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= bus.instr[15:12];
        imm_q <= bus.instr[5:0];
        ra_q  <= bus.instr[11:9];
        rb_q  <= bus.instr[8:6];
        wa_q  <= (bus.instr[15:12] == OPC_ADI) ? bus.instr[8:6] : bus.instr[5:3];
      end
      if (state_q == OPS) begin
        a_q       <= bus.rf_ra_data;
        b_q       <= is_adi ? imm_sext : bus.rf_rb_data;
        exec_q    <= legal && cond_ok;
        skip_q    <= legal && !cond_ok;
        illegal_q <= !legal;
      end
      if (state_q == EXEC) begin
        res_q   <= bus.alu_out;
        carry_q <= bus.alu_carry;
        zf_q    <= bus.alu_zf;
      end
    end
  end

  // Architectural flags retire only at the end of WB of an executed instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
    end else if ((state_q == WB) && exec_q) begin
      zero_flag_q <= zf_q;
      if (!is_ndu) carry_flag_q <= carry_q;
    end
  end

  assign bus.rf_ra_addr = ra_q;
  assign bus.rf_rb_addr = rb_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rf_wa      = wa_q;
  assign bus.rf_wd      = res_q;
  assign bus.carry_flag = carry_flag_q;
  assign bus.zero_flag  = zero_flag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural register file and ALU around the
// controller; directed instructions push expected retirements into a queue
// that an independent monitor pops on every done pulse.
module tb_alu_issue_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  alu_issue_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: R1=5, R2=3, R4=1, others 0 while reset is low
  logic [DW-1:0] rf [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      rf[1] <= 16'h0005;
      rf[2] <= 16'h0003;
      rf[4] <= 16'h0001;
    end else if (bus.rf_we) begin
      rf[bus.rf_wa] <= bus.rf_wd;
    end
  end
  assign bus.rf_ra_data = rf[bus.rf_ra_addr];
  assign bus.rf_rb_data = rf[bus.rf_rb_addr];

  // ALU: 00 add, 01 sub, 10 nand, 11 constant (passes B)
  logic [DW:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      2'b00: alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01: alu_res = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
      2'b10: alu_res = {1'b0, ~(bus.alu_a & bus.alu_b)};
      default: alu_res = {1'b0, bus.alu_b};
    endcase
  end
  assign bus.alu_out   = alu_res[DW-1:0];
  assign bus.alu_carry = alu_res[DW];
  assign bus.alu_zf    = (alu_res[DW-1:0] == '0);

  typedef struct {
    string         tag;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    op;
    logic [DW-1:0] b;
    logic          skip;
    logic          ill;
    logic          c;
    logic          z;
    int            done_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [1:0] op,
                              input logic [DW-1:0] b, input logic skip, input logic ill,
                              input logic c, input logic z);
    exp_t e;
    e.tag = tag; e.we = we; e.wa = wa; e.wd = wd; e.op = op; e.b = b;
    e.skip = skip; e.ill = ill; e.c = c; e.z = z; e.done_cyc = 0;
    return e;
  endfunction

  // Offer one instruction, wait (bounded) for acceptance, queue its expectation
  task automatic issue(input logic [15:0] word, input exp_t e_in);
    exp_t e;
    int   waited;
    e = e_in;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = word;
    waited = 0;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({e.tag, "_accept"}, 32'(bus.instr_ready), 32'd1);
    e.done_cyc = cyc + 3;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  // Monitor: compare every retirement against the queue head, flags one cycle later
  initial begin
    exp_t       e;
    exp_t       flag_e;
    logic       flag_pending;
    logic [1:0] prev_op;
    logic [DW-1:0] prev_b;
    flag_pending = 1'b0;
    prev_op = '0;
    prev_b  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        flag_pending = 1'b0;
      end else begin
        if (flag_pending) begin
          check({flag_e.tag, "_carry_flag"}, 32'(bus.carry_flag), 32'(flag_e.c));
          check({flag_e.tag, "_zero_flag"},  32'(bus.zero_flag),  32'(flag_e.z));
          flag_pending = 1'b0;
        end
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
            check({e.tag, "_rf_we"},   32'(bus.rf_we),   32'(e.we));
            check({e.tag, "_skipped"}, 32'(bus.skipped), 32'(e.skip));
            check({e.tag, "_illegal"}, 32'(bus.illegal), 32'(e.ill));
            if (e.we) begin
              check({e.tag, "_rf_wa"},  32'(bus.rf_wa), 32'(e.wa));
              check({e.tag, "_rf_wd"},  32'(bus.rf_wd), 32'(e.wd));
              check({e.tag, "_alu_op"}, 32'(prev_op),   32'(e.op));
              check({e.tag, "_alu_b"},  32'(prev_b),    32'(e.b));
            end
            flag_e = e;
            flag_pending = 1'b1;
          end
        end
        prev_op = bus.alu_op;
        prev_b  = bus.alu_b;
      end
    end
  end

  initial begin
    logic [15:0] words [3];
    int t0;
    int we_seen;
    int waited;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;

    // Reset state
    #1;
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_outputs", {bus.done, bus.rf_we, bus.skipped, bus.illegal,
                          bus.carry_flag, bus.zero_flag, bus.alu_op}, 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_rf_wd", 32'(bus.rf_wd), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single instructions: tag, we, wa, wd, op, b, skip, ill, C, Z after
    issue(16'h0298, mk("add_r3",     1, 3, 16'h0008, 2'b00, 16'h0003, 0, 0, 0, 0));
    issue(16'h18BF, mk("adi_m1",     1, 2, 16'h0000, 2'b00, 16'hFFFF, 0, 0, 1, 1));
    issue(16'h0268, mk("add_r5",     1, 5, 16'h000A, 2'b00, 16'h0005, 0, 0, 0, 0));
    issue(16'h2371, mk("ndu_skip",   0, 0, 16'h0000, 2'b10, 16'h0000, 1, 0, 0, 0));
    issue(16'h18BF, mk("adi_setz",   1, 2, 16'h0000, 2'b00, 16'hFFFF, 0, 0, 1, 1));
    issue(16'h2371, mk("ndu_exec",   1, 6, 16'hFFFF, 2'b10, 16'h000A, 0, 0, 1, 0));
    issue(16'h5298, mk("opc_0101",   0, 0, 16'h0000, 2'b00, 16'h0000, 0, 1, 1, 0));
    issue(16'h029B, mk("add_cz11",   0, 0, 16'h0000, 2'b00, 16'h0000, 0, 1, 1, 0));
    issue(16'h02BA, mk("add_c_cond", 1, 7, 16'h0005, 2'b00, 16'h0000, 0, 0, 0, 0));

    // Back-to-back with instr_valid held: accepts every 4 cycles
    repeat (6) @(negedge clk);
    words[0] = 16'h0318;
    words[1] = 16'h19C1;
    words[2] = 16'h2900;
    t0 = cyc;
    sb_q.push_back(mk("b2b_add", 1, 3, 16'h0006, 2'b00, 16'h0001, 0, 0, 0, 0));
    sb_q[sb_q.size()-1].done_cyc = t0 + 3;
    sb_q.push_back(mk("b2b_adi", 1, 7, 16'h0002, 2'b00, 16'h0001, 0, 0, 0, 0));
    sb_q[sb_q.size()-1].done_cyc = t0 + 7;
    sb_q.push_back(mk("b2b_ndu", 1, 0, 16'hFFFE, 2'b10, 16'h0001, 0, 0, 0, 0));
    sb_q[sb_q.size()-1].done_cyc = t0 + 11;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instr = words[k];
      check($sformatf("b2b_ready_c%0d", cyc - t0), 32'(bus.instr_ready), 32'd1);
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        check($sformatf("b2b_busy_c%0d", cyc - t0), 32'(bus.instr_ready), 32'd0);
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;

    // Set both flags, then reset during EXEC of an NDU
    issue(16'h18BF, mk("adi_pre_rst", 1, 2, 16'h0000, 2'b00, 16'hFFFF, 0, 0, 1, 1));
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h2900;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;   // now in OPS
    @(negedge clk);
    @(negedge clk);              // EXEC
    check("pre_rst_alu_op", 32'(bus.alu_op), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("mid_rst_strobes", {bus.done, bus.rf_we, bus.skipped, bus.illegal, bus.alu_op}, 32'd0);
    check("mid_rst_flags", {bus.carry_flag, bus.zero_flag}, 32'd0);
    check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("mid_rst_rf_wa_wd", {bus.rf_wa, bus.rf_wd}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rf_we || bus.done) we_seen++;
    end
    check("post_rst_no_writeback", 32'(we_seen), 32'd0);
    check("post_rst_flags", {bus.carry_flag, bus.zero_flag}, 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
